// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_pkg
//  Description : Shared types for the parametric block RAM: read-during-write
//                mode selector and clear-engine state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

    // Same-address read-during-write behaviour
    typedef enum logic [0:0] {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rdw_mode_t;

    // Clear engine states (only used when BRAM_CLEAR_EN is defined)
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clear_state_t;

endpackage : bram_pkg
`default_nettype wire

// File: rtl/parametric_bram_if.sv
`default_nettype none
// ============================================================================
//  Module      : parametric_bram_if
//  Description : Request/response bundle of the parametric block RAM. The
//                master drives write/read requests, the slave (the RAM)
//                returns read data, qualifiers and ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface parametric_bram_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int BE_WIDTH = DATA_WIDTH / BYTE_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  collision;
    logic                  ready;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, collision, ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, collision, ready
    );

endinterface : parametric_bram_if
`default_nettype wire

// File: rtl/bram_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bram_clear_ctrl
//  Description : Ready generation for the parametric block RAM. With the
//                macro BRAM_CLEAR_EN defined, a CLEAR/RUN engine zeroes every
//                word after reset before raising ready; otherwise ready simply
//                rises one cycle after reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_clear_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    output logic                       ready_o,
    output logic                       clear_we_o,
    output logic [ADDR_WIDTH-1:0]      clear_addr_o
);

`ifdef BRAM_CLEAR_EN
    clear_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // State and clear-address register; reset restarts the sweep at address 0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Advance one word per cycle; leave CLEAR once the last address is written
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) begin
                state_d = RUN;
            end
        end
    end

    // Outputs decoded from state; no clearing writes while reset is held
    always_comb begin
        ready_o      = (state_q == RUN);
        clear_we_o   = (state_q == CLEAR) && reset_n;
        clear_addr_o = cnt_q;
    end
`else
    logic ready_q;

    // Ready rises on the first edge after reset release
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready_o      = ready_q;
    assign clear_we_o   = 1'b0;
    assign clear_addr_o = '0;
`endif

endmodule : bram_clear_ctrl
`default_nettype wire

// File: rtl/parametric_bram.sv
`default_nettype none
// ============================================================================
//  Module      : parametric_bram
//  Description : Simple dual-port block RAM with byte write enables, selectable
//                read-during-write mode, optional output register and a
//                same-address collision flag. Define BRAM_CLEAR_EN to zero the
//                array after every reset before accepting requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module parametric_bram
    import bram_pkg::*;
#(
    parameter int        ADDR_WIDTH = 6,
    parameter int        DATA_WIDTH = 32,
    parameter int        BYTE_WIDTH = 8,
    parameter int        OUT_REG    = 0,
    parameter rdw_mode_t RDW_MODE   = READ_FIRST
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    parametric_bram_if.slave bus
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
        $error("parametric_bram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic                  ready_w;
    logic                  clear_we_w;
    logic [ADDR_WIDTH-1:0] clear_addr_w;

    bram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .ready_o      (ready_w),
        .clear_we_o   (clear_we_w),
        .clear_addr_o (clear_addr_w)
    );

    assign bus.ready = ready_w;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Requests count only while ready and out of reset
    logic wr_acc_w;
    logic rd_acc_w;
    assign wr_acc_w = ready_w && reset_n && bus.wr_en;
    assign rd_acc_w = ready_w && reset_n && bus.rd_en;

    logic [DATA_WIDTH-1:0] old_word_w;
    logic [DATA_WIDTH-1:0] merged_word_w;
    logic [DATA_WIDTH-1:0] rd_word_w;
    logic                  same_addr_w;
    logic                  collide_w;

    // Read word selection: pre-write word, or the byte-merged word when the
    // write lands on the read address in WRITE_FIRST mode
    always_comb begin
        old_word_w    = mem_q[bus.rd_addr];
        merged_word_w = old_word_w;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (bus.wr_be[i]) begin
                merged_word_w[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        same_addr_w = wr_acc_w && (bus.wr_addr == bus.rd_addr) && (|bus.wr_be);
        collide_w   = rd_acc_w && same_addr_w;
        rd_word_w   = ((RDW_MODE == WRITE_FIRST) && same_addr_w) ? merged_word_w : old_word_w;
    end

    // Memory array: clear sweep has priority, user writes are byte-masked
    always_ff @(posedge clk) begin
        if (clear_we_w) begin
            mem_q[clear_addr_w] <= '0;
        end else if (wr_acc_w) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.wr_be[i]) begin
                    mem_q[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic                  s1_valid_q;
    logic                  s1_coll_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    // First read stage; data only moves on an accepted read so it holds otherwise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_coll_q  <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_acc_w;
            s1_coll_q  <= collide_w;
            if (rd_acc_w) begin
                s1_data_q <= rd_word_w;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_q;
        logic                  s2_coll_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        // Optional output stage; keeps collision aligned with rd_valid
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s2_valid_q <= 1'b0;
                s2_coll_q  <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_coll_q  <= s1_coll_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign bus.rd_valid  = s2_valid_q;
        assign bus.collision = s2_coll_q;
        assign bus.rd_data   = s2_data_q;
    end else begin : g_no_out_reg
        assign bus.rd_valid  = s1_valid_q;
        assign bus.collision = s1_coll_q;
        assign bus.rd_data   = s1_data_q;
    end

endmodule : parametric_bram
`default_nettype wire

// File: tb/tb_parametric_bram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parametric_bram
//  Description : Directed self-checking bench. dut0 is OUT_REG=0/READ_FIRST,
//                dut1 is OUT_REG=1/WRITE_FIRST; both see identical requests.
//                Build with BRAM_CLEAR_EN to exercise the clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parametric_bram;
    import bram_pkg::*;

`ifdef BRAM_CLEAR_EN
    localparam int          EXP_READY = 16;
    localparam logic [31:0] EXP_ADDR7 = 32'h0000_0000;
`else
    localparam int          EXP_READY = 1;
    localparam logic [31:0] EXP_ADDR7 = 32'h0000_0077;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    parametric_bram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus0 ();
    parametric_bram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus1 ();

    assign bus1.wr_en   = bus0.wr_en;
    assign bus1.wr_addr = bus0.wr_addr;
    assign bus1.wr_data = bus0.wr_data;
    assign bus1.wr_be   = bus0.wr_be;
    assign bus1.rd_en   = bus0.rd_en;
    assign bus1.rd_addr = bus0.rd_addr;

    parametric_bram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(0), .RDW_MODE(READ_FIRST)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    parametric_bram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUT_REG(1), .RDW_MODE(WRITE_FIRST)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    // Snapshot of both DUTs at the two negedges following a request
    typedef struct {
        logic        v0a, c0a, v1a;
        logic [31:0] d0a;
        logic        v0b, c0b, v1b, c1b;
        logic [31:0] d0b, d1b;
    } obs_t;

    task automatic set_req(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                           input logic [3:0] be, input logic re, input logic [3:0] ra);
        bus0.wr_en   = we;
        bus0.wr_addr = wa;
        bus0.wr_data = wd;
        bus0.wr_be   = be;
        bus0.rd_en   = re;
        bus0.rd_addr = ra;
    endtask

    // Called at a negedge: present one request for one edge, then sample twice
    task automatic xact(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic re, input logic [3:0] ra,
                        output obs_t o);
        set_req(we, wa, wd, be, re, ra);
        @(negedge clk);
        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
        o.v0a = bus0.rd_valid; o.c0a = bus0.collision; o.d0a = bus0.rd_data;
        o.v1a = bus1.rd_valid;
        @(negedge clk);
        o.v0b = bus0.rd_valid; o.c0b = bus0.collision; o.d0b = bus0.rd_data;
        o.v1b = bus1.rd_valid; o.c1b = bus1.collision; o.d1b = bus1.rd_data;
    endtask

    // Called at the release negedge: count cycles until ready, note any rd_valid
    task automatic wait_ready(output int cyc, output logic saw_v);
        cyc   = 0;
        saw_v = 1'b0;
        while (bus0.ready !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus0.rd_valid !== 1'b0 || bus1.rd_valid !== 1'b0) saw_v = 1'b1;
        end
    endtask

    task automatic test_reset();
        int   cyc;
        logic sv;
        reset_n = 1'b0;
        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus0.ready, bus0.rd_valid, bus0.collision, bus0.rd_data} !== 35'h0)
            $display("FAIL reset_dut0: got %h want 0", {bus0.ready, bus0.rd_valid, bus0.collision, bus0.rd_data});
        else n_pass++;
        n_checks++;
        if ({bus1.ready, bus1.rd_valid, bus1.collision, bus1.rd_data} !== 35'h0)
            $display("FAIL reset_dut1: got %h want 0", {bus1.ready, bus1.rd_valid, bus1.collision, bus1.rd_data});
        else n_pass++;
        reset_n = 1'b1;
        wait_ready(cyc, sv);
        n_checks++;
        if (cyc != EXP_READY || sv !== 1'b0)
            $display("FAIL ready_after_reset: got cycles=%0d valid_seen=%b want cycles=%0d valid_seen=0", cyc, sv, EXP_READY);
        else n_pass++;
        n_checks++;
        if (bus1.ready !== 1'b1)
            $display("FAIL ready_dut1: got %b want 1", bus1.ready);
        else n_pass++;
    endtask

    task automatic test_byte_enable();
        obs_t o;
        xact(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, 4'd0, o);
        xact(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0, o);
        xact(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, o);
        n_checks++;
        if ({o.v0a, o.c0a, o.d0a, o.v1a} !== {1'b1, 1'b0, 32'hAA22CC44, 1'b0})
            $display("FAIL be_merge_lat1: got v0=%b c0=%b d0=%h v1=%b want v0=1 c0=0 d0=aa22cc44 v1=0", o.v0a, o.c0a, o.d0a, o.v1a);
        else n_pass++;
        n_checks++;
        if ({o.v0b, o.d0b, o.v1b, o.c1b, o.d1b} !== {1'b0, 32'hAA22CC44, 1'b1, 1'b0, 32'hAA22CC44})
            $display("FAIL be_merge_lat2: got v0=%b d0=%h v1=%b c1=%b d1=%h want v0=0 d0=aa22cc44 v1=1 c1=0 d1=aa22cc44", o.v0b, o.d0b, o.v1b, o.c1b, o.d1b);
        else n_pass++;
        // wr_be = 0 on the read address: no write and no collision
        xact(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b1, 4'd3, o);
        n_checks++;
        if ({o.c0a, o.d0a, o.c1b, o.d1b} !== {1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44})
            $display("FAIL be_zero_same: got c0=%b d0=%h c1=%b d1=%h want c=0 d=aa22cc44", o.c0a, o.d0a, o.c1b, o.d1b);
        else n_pass++;
        xact(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, o);
        n_checks++;
        if ({o.v0a, o.d0a, o.v1b, o.d1b} !== {1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44})
            $display("FAIL be_zero_noop: got d0=%h d1=%h want aa22cc44", o.d0a, o.d1b);
        else n_pass++;
    endtask

    task automatic test_collision();
        obs_t o;
        xact(1'b1, 4'd5, 32'h0, 4'b1111, 1'b0, 4'd0, o);
        xact(1'b1, 4'd5, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'd5, o);
        n_checks++;
        if ({o.v0a, o.c0a, o.d0a} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL coll_read_first: got v=%b c=%b d=%h want v=1 c=1 d=00000000", o.v0a, o.c0a, o.d0a);
        else n_pass++;
        n_checks++;
        if ({o.v1b, o.c1b, o.d1b} !== {1'b1, 1'b1, 32'hFFFFFFFF})
            $display("FAIL coll_write_first: got v=%b c=%b d=%h want v=1 c=1 d=ffffffff", o.v1b, o.c1b, o.d1b);
        else n_pass++;
        n_checks++;
        if ({o.v0b, o.c0b, o.v1a} !== 3'b000)
            $display("FAIL coll_alignment: got v0b=%b c0b=%b v1a=%b want 000", o.v0b, o.c0b, o.v1a);
        else n_pass++;
        xact(1'b1, 4'd5, 32'h12345678, 4'b0011, 1'b1, 4'd5, o);
        n_checks++;
        if ({o.c0a, o.d0a, o.c1b, o.d1b} !== {1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFF5678})
            $display("FAIL coll_partial: got c0=%b d0=%h c1=%b d1=%h want c0=1 d0=ffffffff c1=1 d1=ffff5678", o.c0a, o.d0a, o.c1b, o.d1b);
        else n_pass++;
        xact(1'b1, 4'd6, 32'hCAFEF00D, 4'b1111, 1'b1, 4'd5, o);
        n_checks++;
        if ({o.v0a, o.c0a, o.d0a, o.v1b, o.c1b, o.d1b} !== {1'b1, 1'b0, 32'hFFFF5678, 1'b1, 1'b0, 32'hFFFF5678})
            $display("FAIL coll_diff_addr: got c0=%b d0=%h c1=%b d1=%h want c=0 d=ffff5678", o.c0a, o.d0a, o.c1b, o.d1b);
        else n_pass++;
        xact(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd6, o);
        n_checks++;
        if ({o.d0a, o.d1b} !== {32'hCAFEF00D, 32'hCAFEF00D})
            $display("FAIL diff_addr_write: got d0=%h d1=%h want cafef00d", o.d0a, o.d1b);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            set_req(1'b1, 4'(i), 32'h100 + 32'(i), 4'b1111, 1'b0, 4'd0);
            @(negedge clk);
        end
        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    endtask

    // Reads of 0..15 on consecutive cycles; each DUT must stream results in order
    task automatic test_back_to_back(input logic expect_zero);
        logic        e0v, e1v;
        logic [31:0] e0d, e1d;
        @(negedge clk);
        for (int k = 0; k < 18; k++) begin
            e0v = (k >= 1 && k <= 16);
            e1v = (k >= 2);
            e0d = expect_zero ? 32'h0 : 32'h100 + 32'(k - 1);
            e1d = expect_zero ? 32'h0 : 32'h100 + 32'(k - 2);
            n_checks++;
            if (bus0.rd_valid !== e0v || (e0v && bus0.rd_data !== e0d))
                $display("FAIL b2b_dut0[%0d]: got v=%b d=%h want v=%b d=%h", k, bus0.rd_valid, bus0.rd_data, e0v, e0d);
            else n_pass++;
            n_checks++;
            if (bus1.rd_valid !== e1v || (e1v && bus1.rd_data !== e1d))
                $display("FAIL b2b_dut1[%0d]: got v=%b d=%h want v=%b d=%h", k, bus1.rd_valid, bus1.rd_data, e1v, e1d);
            else n_pass++;
            if (k < 16) set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(k));
            else        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_not_ready();
        obs_t o;
        int   cyc;
        xact(1'b1, 4'd7, 32'h00000077, 4'b1111, 1'b0, 4'd0, o);
        reset_n = 1'b0;
        set_req(1'b1, 4'd7, 32'hDEADBEEF, 4'b1111, 1'b1, 4'd7);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({bus0.rd_valid, bus1.rd_valid, bus0.ready} !== 3'b000)
                $display("FAIL notready_reset: got v0=%b v1=%b rdy=%b want 000", bus0.rd_valid, bus1.rd_valid, bus0.ready);
            else n_pass++;
        end
        reset_n = 1'b1;
        cyc = 0;
        while (bus0.ready !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if ({bus0.rd_valid, bus1.rd_valid} !== 2'b00)
                $display("FAIL notready_valid[%0d]: got v0=%b v1=%b want 00", cyc, bus0.rd_valid, bus1.rd_valid);
            else n_pass++;
        end
        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
        n_checks++;
        if (cyc != EXP_READY)
            $display("FAIL notready_ready: got cycles=%0d want %0d", cyc, EXP_READY);
        else n_pass++;
        xact(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, o);
        n_checks++;
        if ({o.v0a, o.d0a, o.v1b, o.d1b} !== {1'b1, EXP_ADDR7, 1'b1, EXP_ADDR7})
            $display("FAIL notready_mem: got d0=%h d1=%h want %h", o.d0a, o.d1b, EXP_ADDR7);
        else n_pass++;
    endtask

    task automatic test_reset_flush();
        int   cyc;
        logic sv;
        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd3);
        @(negedge clk);
        n_checks++;
        if (bus0.rd_valid !== 1'b1)
            $display("FAIL flush_pre: got v0=%b want 1", bus0.rd_valid);
        else n_pass++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
        n_checks++;
        if ({bus0.rd_valid, bus0.rd_data, bus1.rd_valid, bus1.rd_data, bus1.collision} !== 67'h0)
            $display("FAIL flush_reset_edge: got v0=%b d0=%h v1=%b d1=%h want all 0", bus0.rd_valid, bus0.rd_data, bus1.rd_valid, bus1.rd_data);
        else n_pass++;
        wait_ready(cyc, sv);
        n_checks++;
        if (cyc != EXP_READY || sv !== 1'b0)
            $display("FAIL flush_after: got cycles=%0d valid_seen=%b want cycles=%0d valid_seen=0", cyc, sv, EXP_READY);
        else n_pass++;
    endtask

`ifdef BRAM_CLEAR_EN
    task automatic test_clear_restart();
        int   cyc;
        logic sv;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (9) @(negedge clk);
        n_checks++;
        if (bus0.ready !== 1'b0)
            $display("FAIL clear_mid: got ready=%b want 0", bus0.ready);
        else n_pass++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(cyc, sv);
        n_checks++;
        if (cyc != 16)
            $display("FAIL clear_restart: got cycles=%0d want 16", cyc);
        else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
        test_reset();
`ifdef BRAM_CLEAR_EN
        test_back_to_back(1'b1);
`endif
        test_byte_enable();
        test_collision();
        test_fill();
        test_back_to_back(1'b0);
        test_not_ready();
        test_reset_flush();
`ifdef BRAM_CLEAR_EN
        test_clear_restart();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_parametric_bram
`default_nettype wire
